// File: rtl/hilo_acc_unit.sv
// HI/LO result register pair with a scoreboard for a variable-latency MD unit,
// MADD/MSUB-style accumulate into {HI,LO} and a stall output while a result is pending.
module hilo_acc_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter bit          ACC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             md_start,
  input  logic [1:0]       md_op,
  input  logic             md_done,
  input  logic [WIDTH-1:0] md_hi,
  input  logic [WIDTH-1:0] md_lo,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] mt_wdata,
  input  logic             rd_req,
  output logic [WIDTH-1:0] hi_rdata,
  output logic [WIDTH-1:0] lo_rdata,
  output logic             busy,
  output logic             stall
);

  localparam int unsigned DW = 2 * WIDTH;

  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACC  = 2'd2
  } state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [DW-1:0]    opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;

  logic [DW-1:0]    hilo;
  logic [DW-1:0]    acc_res;
  logic             acc_take;

  // Full-width add/sub so carry and borrow cross from LO into HI.
  assign hilo     = {hi_q, lo_q};
  assign acc_res  = (op_q == OP_SUB) ? (hilo - opnd_q) : (hilo + opnd_q);
  assign acc_take = ACC_EN && ((op_q == OP_ADD) || (op_q == OP_SUB));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 2'b00;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // md_done here is stale and ignored.
          if (mthi_we) hi_q <= mt_wdata;
          if (mtlo_we) lo_q <= mt_wdata;
          if (md_start) begin
            op_q    <= md_op;
            state_q <= S_WAIT;
            busy_q  <= 1'b1;
          end
        end
        S_WAIT: begin
          if (md_done) begin
            if (acc_take) begin
              opnd_q  <= {md_hi, md_lo};
              state_q <= S_ACC;
            end else begin
              hi_q    <= md_hi;
              lo_q    <= md_lo;
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        S_ACC: begin
          {hi_q, lo_q} <= acc_res;
          state_q      <= S_IDLE;
          busy_q       <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign hi_rdata = hi_q;
  assign lo_rdata = lo_q;
  assign busy     = busy_q;
  // Requests that would touch HI/LO are held off while a result is in flight.
  assign stall    = busy_q & (rd_req | mthi_we | mtlo_we | md_start);

endmodule

// File: tb/tb_hilo_acc_unit.sv
// Directed bench for hilo_acc_unit: one accumulate-enabled and one accumulate-disabled
// instance share stimulus; MD results are scoreboarded from issue to completion.
module tb_hilo_acc_unit;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         md_start, md_done, mthi_we, mtlo_we, rd_req;
  logic [1:0]   md_op;
  logic [W-1:0] md_hi, md_lo, mt_wdata;

  logic [W-1:0] hi1, lo1, hi0, lo0;
  logic         busy1, stall1, busy0, stall0;

  int errors = 0;
  int checks = 0;

  logic [2*W-1:0] m1, m0;
  logic [2*W-1:0] q1[$];
  logic [2*W-1:0] q0[$];

  always #5 clk = ~clk;

  hilo_acc_unit #(.WIDTH(W), .ACC_EN(1'b1)) u_acc (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op), .md_done(md_done),
    .md_hi(md_hi), .md_lo(md_lo), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .mt_wdata(mt_wdata), .rd_req(rd_req), .hi_rdata(hi1), .lo_rdata(lo1),
    .busy(busy1), .stall(stall1)
  );

  hilo_acc_unit #(.WIDTH(W), .ACC_EN(1'b0)) u_noacc (
    .clk(clk), .reset(reset), .md_start(md_start), .md_op(md_op), .md_done(md_done),
    .md_hi(md_hi), .md_lo(md_lo), .mthi_we(mthi_we), .mtlo_we(mtlo_we),
    .mt_wdata(mt_wdata), .rd_req(rd_req), .hi_rdata(hi0), .lo_rdata(lo0),
    .busy(busy0), .stall(stall0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_both(input string tag);
    chk({tag, "_acc_hilo"}, {hi1, lo1}, m1);
    chk({tag, "_noacc_hilo"}, {hi0, lo0}, m0);
  endtask

  // MT write while idle; both instances see the same data.
  task automatic mt(input logic whi, input logic wlo, input logic [W-1:0] d);
    mthi_we = whi; mtlo_we = wlo; mt_wdata = d;
    tick();
    mthi_we = 1'b0; mtlo_we = 1'b0;
    if (whi) begin m1[2*W-1:W] = d; m0[2*W-1:W] = d; end
    if (wlo) begin m1[W-1:0] = d; m0[W-1:0] = d; end
  endtask

  // Issue an MD op, complete it after lat cycles, and retire it from the scoreboard.
  task automatic run_md(input string tag, input logic [1:0] op, input int lat,
                        input logic [W-1:0] dhi, input logic [W-1:0] dlo);
    logic [2*W-1:0] r, e1, e0, old1;
    logic           is_acc;
    is_acc = (op == 2'b01) || (op == 2'b10);
    r = {dhi, dlo};
    old1 = m1;
    if (op == 2'b01)      q1.push_back(m1 + r);
    else if (op == 2'b10) q1.push_back(m1 - r);
    else                  q1.push_back(r);
    q0.push_back(r);
    md_start = 1'b1; md_op = op;
    tick();
    md_start = 1'b0;
    for (int i = 1; i < lat; i++) begin
      chk({tag, "_busy_wait"}, {63'd0, busy1}, 64'd1);
      if (i == 1) begin
        rd_req = 1'b1;
        #1;
        chk({tag, "_stall_rd"}, {62'd0, stall1, stall0}, 64'd3);
        rd_req = 1'b0;
      end
      tick();
    end
    md_done = 1'b1; md_hi = dhi; md_lo = dlo;
    tick();
    md_done = 1'b0;
    chk({tag, "_noacc_busy_done"}, {63'd0, busy0}, 64'd0);
    if (is_acc) begin
      chk({tag, "_acc_busy_in_acc"}, {63'd0, busy1}, 64'd1);
      chk({tag, "_acc_hilo_before_acc"}, {hi1, lo1}, old1);
      tick();
    end
    chk({tag, "_acc_busy_end"}, {63'd0, busy1}, 64'd0);
    e1 = q1.pop_front();
    e0 = q0.pop_front();
    m1 = e1; m0 = e0;
    chk_both(tag);
  endtask

  initial begin
    reset = 1'b1;
    md_start = 1'b0; md_done = 1'b0; mthi_we = 1'b0; mtlo_we = 1'b0; rd_req = 1'b0;
    md_op = 2'b00; md_hi = '0; md_lo = '0; mt_wdata = '0;
    m1 = '0; m0 = '0;
    tick(); tick();
    reset = 1'b0;
    chk_both("reset");
    chk("reset_busy", {62'd0, busy1, busy0}, 64'd0);
    chk("reset_stall", {62'd0, stall1, stall0}, 64'd0);

    // MT writes, both enables together, then LO alone
    mt(1'b1, 1'b1, 32'hDEADBEEF);
    chk_both("mt_both");
    mt(1'b0, 1'b1, 32'h12345678);
    chk_both("mt_lo");
    rd_req = 1'b1;
    #1;
    chk("idle_rd_no_stall", {62'd0, stall1, stall0}, 64'd0);
    rd_req = 1'b0;

    // Asynchronous reset mid-cycle
    #2;
    reset = 1'b1;
    #1;
    m1 = '0; m0 = '0;
    chk_both("async_reset");
    chk("async_reset_busy", {62'd0, busy1, busy0}, 64'd0);
    tick();
    reset = 1'b0;

    run_md("mult", 2'b00, 3, 32'h1, 32'h2);

    mt(1'b1, 1'b0, 32'h0);
    mt(1'b0, 1'b1, 32'hFFFFFFFF);
    run_md("madd", 2'b01, 2, 32'h0, 32'h1);

    mt(1'b1, 1'b1, 32'h0);
    run_md("msub", 2'b10, 2, 32'h0, 32'h1);

    // Dropped requests while busy; same-cycle md_done with md_start ignored
    mt(1'b1, 1'b1, 32'h11111111);
    md_start = 1'b1; md_op = 2'b00; md_done = 1'b1; md_hi = 32'h9; md_lo = 32'h9;
    tick();
    md_start = 1'b0; md_done = 1'b0;
    chk("early_done_busy", {62'd0, busy1, busy0}, 64'd3);
    chk_both("early_done_ignored");
    mthi_we = 1'b1; mt_wdata = 32'hAAAA5555;
    #1;
    chk("mthi_stall", {62'd0, stall1, stall0}, 64'd3);
    tick();
    mthi_we = 1'b0;
    chk_both("mthi_dropped");
    md_start = 1'b1;
    #1;
    chk("start_stall", {62'd0, stall1, stall0}, 64'd3);
    tick();
    md_start = 1'b0;
    md_done = 1'b1; md_hi = 32'h3; md_lo = 32'h4; mthi_we = 1'b1;
    #1;
    chk("done_cycle_stall", {62'd0, stall1, stall0}, 64'd3);
    tick();
    md_done = 1'b0; mthi_we = 1'b0;
    m1 = {32'h3, 32'h4}; m0 = m1;
    chk_both("done_with_mthi");
    chk("done_busy_low", {62'd0, busy1, busy0}, 64'd0);
    tick();
    chk("no_second_op", {62'd0, busy1, busy0}, 64'd0);
    md_done = 1'b1; md_hi = 32'hBAD; md_lo = 32'hBAD;
    tick();
    md_done = 1'b0;
    chk_both("idle_done_ignored");

    // Reset aborts a pending op; a later md_done is ignored
    md_start = 1'b1; md_op = 2'b00;
    tick();
    md_start = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    m1 = '0; m0 = '0;
    chk("abort_busy", {62'd0, busy1, busy0}, 64'd0);
    tick();
    reset = 1'b0;
    md_done = 1'b1; md_hi = 32'h7; md_lo = 32'h8;
    tick();
    md_done = 1'b0;
    chk_both("abort_done_ignored");
    chk("abort_idle", {62'd0, busy1, busy0}, 64'd0);

    // Accumulate op: plain write with ACC_EN=0, accumulate with ACC_EN=1
    mt(1'b1, 1'b1, 32'h00000010);
    run_md("accen", 2'b01, 2, 32'h5, 32'h6);
    run_md("op11", 2'b11, 2, 32'hCAFEF00D, 32'h0BADBEEF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
